// File: rtl/logic_op_unit.sv
// Purpose : switch-to-LED bitwise logic selector with input sync/debounce and a step mode
//           where the result feeds back as operand A once per debounced button press.
// Latency : raw input held stable -> led update = SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
// Backpressure: none; free-running, every input is sampled every cycle.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   sw_a, sw_b [WIDTH]    raw operand switches
//   sw_op [3]             raw opcode switches
//   sw_mode               raw mode switch (0 = live, 1 = step)
//   sw_step               raw step push-button
//   led [WIDTH]           registered logic result
//   led_any               registered OR-reduction of led
//   changed               one-cycle pulse coincident with a new led value
module logic_op_unit #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_a,
    input  logic [WIDTH-1:0] sw_b,
    input  logic [2:0]       sw_op,
    input  logic             sw_mode,
    input  logic             sw_step,
    output logic [WIDTH-1:0] led,
    output logic             led_any,
    output logic             changed
);

    localparam int N  = 2*WIDTH + 5;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // All raw inputs handled as one flat vector so sync and debounce are uniform per bit.
    logic [N-1:0] raw;
    assign raw = {sw_step, sw_mode, sw_op, sw_b, sw_a};

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-bit debounce: a new level is accepted on its DEBOUNCE_CYCLES-th
    // consecutive mismatching cycle; any return to the accepted level
    // clears the count, so short glitches never get through.
    // ------------------------------------------------------------------
    logic [N-1:0]  db_q;
    logic [CW-1:0] cnt_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (synced[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    db_q[i]  <= synced[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    logic [WIDTH-1:0] db_a;
    logic [WIDTH-1:0] db_b;
    logic [2:0]       db_op;
    logic             db_mode;
    logic             db_step;

    assign db_a    = db_q[WIDTH-1:0];
    assign db_b    = db_q[2*WIDTH-1:WIDTH];
    assign db_op   = db_q[2*WIDTH+2:2*WIDTH];
    assign db_mode = db_q[2*WIDTH+3];
    assign db_step = db_q[2*WIDTH+4];

    // ------------------------------------------------------------------
    // Logic function
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = ~x;
            3'b001:  r = x;
            3'b010:  r = ~(x ^ b);
            3'b011:  r = x ^ b;
            3'b100:  r = x | b;
            3'b101:  r = ~(x | b);
            3'b110:  r = x & b;
            default: r = ~(x & b);
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Step edge detect and result selection
    // ------------------------------------------------------------------
    logic             step_prev;
    logic             step_rise;
    logic [WIDTH-1:0] next_led;

    assign step_rise = db_step & ~step_prev;

    // Mode and step are both debounced values of this cycle, so a press
    // only acts once debounced mode is already 1.
    always_comb begin
        next_led = led;
        if (!db_mode) begin
            next_led = logic_fn(db_op, db_a, db_b);
        end else if (step_rise) begin
            next_led = logic_fn(db_op, led, db_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_prev <= 1'b0;
            led       <= '0;
            led_any   <= 1'b0;
            changed   <= 1'b0;
        end else begin
            step_prev <= db_step;
            led       <= next_led;
            led_any   <= |next_led;
            changed   <= (next_led != led);
        end
    end

endmodule
